// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and hands the decoder one instruction (or a NOP) with its PC and PC+4.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module fetch_unit #(
  parameter logic [31:0]            RESET_PC = 32'h0000_0000,
  parameter logic [`INST_WIDTH-1:0] NOP_INST = `INST_WIDTH'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   o_imem_req,
  output logic [31:0]            o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [`INST_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  input  logic                   i_stall,
  output logic [`INST_WIDTH-1:0] o_inst,
  output logic                   o_inst_valid,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_pc_plus4
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [31:0]            pc_r;
  logic [31:0]            pc_nxt_s;
  logic [`INST_WIDTH-1:0] inst_r;
  logic [`INST_WIDTH-1:0] inst_nxt_s;
  logic                   kill_r;
  logic                   kill_nxt_s;
  logic [31:0]            pend_pc_r;
  logic [31:0]            pend_pc_nxt_s;
  logic [31:0]            redirect_pc_s;
  logic [31:0]            pc_plus4_s;

  assign redirect_pc_s = {i_redirect_pc[31:2], 2'b00};
  assign pc_plus4_s    = pc_r + 32'd4;

  // Next-state logic for the fetch FSM and its PC / kill bookkeeping.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    inst_nxt_s    = inst_r;
    kill_nxt_s    = kill_r;
    pend_pc_nxt_s = pend_pc_r;
    case (state_r)
      S_RESET: begin
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          // A redirect coinciding with the ack supersedes any earlier pending target.
          if (i_redirect) begin
            pc_nxt_s   = redirect_pc_s;
            kill_nxt_s = 1'b0;
          end else if (kill_r) begin
            pc_nxt_s   = pend_pc_r;
            kill_nxt_s = 1'b0;
          end else begin
            inst_nxt_s  = i_imem_rdata;
            state_nxt_s = S_VALID;
          end
        end else if (i_redirect) begin
          // Read at the old address is still in flight; remember where to go after it.
          kill_nxt_s    = 1'b1;
          pend_pc_nxt_s = redirect_pc_s;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_VALID: begin
        if (i_redirect) begin
          pc_nxt_s    = redirect_pc_s;
          state_nxt_s = S_FETCH;
        end else if (!i_stall) begin
          pc_nxt_s    = pc_plus4_s;
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_VALID;
        end
      end
      default: begin
        state_nxt_s = S_RESET;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_RESET;
      pc_r      <= RESET_PC;
      inst_r    <= NOP_INST;
      kill_r    <= 1'b0;
      pend_pc_r <= RESET_PC;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      inst_r    <= inst_nxt_s;
      kill_r    <= kill_nxt_s;
      pend_pc_r <= pend_pc_nxt_s;
    end
  end

  // Outputs are pure decodes of registered state; rdata never reaches o_inst directly.
  assign o_imem_req   = (state_r == S_FETCH);
  assign o_imem_addr  = pc_r;
  assign o_inst_valid = (state_r == S_VALID);
  assign o_inst       = (state_r == S_VALID) ? inst_r : NOP_INST;
  assign o_pc         = pc_r;
  assign o_pc_plus4   = pc_plus4_s;

endmodule
